// File: rtl/fb_if_stage_pkg.sv
// ---------------------------------------------------------------------------
// fb_if_stage_pkg
//   Shared definitions for the Firebird instruction-fetch stage: datapath
//   width, reset/bubble constants, the fetch FSM state encoding and a small
//   helper for the sequential PC increment.
//   No ports (package only).
// ---------------------------------------------------------------------------
package fb_if_stage_pkg;

  localparam int FB_32BITS = 32;

  localparam logic [FB_32BITS-1:0] FB_NOP_INST = 32'h0000_0013;
  localparam logic [FB_32BITS-1:0] FB_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FB_IF_IDLE    = 2'd0,
    FB_IF_FETCH   = 2'd1,
    FB_IF_HOLD    = 2'd2,
    FB_IF_DISCARD = 2'd3
  } fb_if_state_e;

  // PCs are word addresses, so the sequential successor is +1 and simply
  // wraps at the top of the 32-bit space.
  function automatic logic [FB_32BITS-1:0] fb_next_pc(input logic [FB_32BITS-1:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/fb_if_id_reg.sv
// ---------------------------------------------------------------------------
// fb_if_id_reg
//   IF/ID pipeline register holding {pc, inst, valid}. Each cycle it either
//   loads a new fetched instruction, inserts a bubble (valid=0, NOP, pc=0)
//   or holds its contents. Bubble wins over load so a flush can never be
//   overridden by a fetch in the same cycle.
//   Ports:
//     clk, rst            clock, async active-high reset (resets to bubble)
//     load                capture pc_i/inst_i as a valid instruction
//     bubble              replace contents with a bubble
//     pc_i, inst_i        incoming instruction and its PC
//     pc_o, inst_o,       registered IF/ID contents
//     valid_o
// ---------------------------------------------------------------------------
module fb_if_id_reg
  import fb_if_stage_pkg::*;
#(
  parameter logic [FB_32BITS-1:0] NOP_INST = FB_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bubble,
  input  logic [FB_32BITS-1:0] pc_i,
  input  logic [FB_32BITS-1:0] inst_i,
  output logic [FB_32BITS-1:0] pc_o,
  output logic [FB_32BITS-1:0] inst_o,
  output logic                 valid_o
);

  logic [FB_32BITS-1:0] pc_q, pc_d;
  logic [FB_32BITS-1:0] inst_q, inst_d;
  logic                 valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (bubble) begin
      pc_d    = '0;
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fb_if_stage.sv
// ---------------------------------------------------------------------------
// fb_if_stage
//   Firebird instruction-fetch stage. Owns the PC, runs the single-
//   outstanding instruction-memory handshake and feeds the IF/ID register.
//   A one-entry skid buffer absorbs a fetch accepted while ID is stalled,
//   and a discard state keeps an in-flight request stable after a redirect
//   until memory accepts it, then throws the data away.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     stall                    ID load-use hold, freezes IF/ID
//     address_src, register_rst  prediction-error / flush (override stall)
//     predict_err_pc           recovery target for address_src/register_rst
//     pred_take, predict_pc    static prediction redirect from ID
//     imem_req, imem_addr      fetch request (registered / state-decoded)
//     imem_ready, imem_rdata   accept strobe with same-cycle data
//     if_id_pc, if_id_inst,    IF/ID register contents
//     if_id_valid
// ---------------------------------------------------------------------------
module fb_if_stage
  import fb_if_stage_pkg::*;
#(
  parameter logic [FB_32BITS-1:0] RESET_PC = FB_RESET_PC,
  parameter logic [FB_32BITS-1:0] NOP_INST = FB_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 address_src,
  input  logic                 register_rst,
  input  logic [FB_32BITS-1:0] predict_err_pc,
  input  logic                 pred_take,
  input  logic [FB_32BITS-1:0] predict_pc,
  output logic                 imem_req,
  output logic [FB_32BITS-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic [FB_32BITS-1:0] imem_rdata,
  output logic [FB_32BITS-1:0] if_id_pc,
  output logic [FB_32BITS-1:0] if_id_inst,
  output logic                 if_id_valid
);

  fb_if_state_e         state_q, state_d;
  logic [FB_32BITS-1:0] pc_q, pc_d;
  logic [FB_32BITS-1:0] buf_pc_q, buf_pc_d;
  logic [FB_32BITS-1:0] buf_inst_q, buf_inst_d;
  logic [FB_32BITS-1:0] dis_addr_q, dis_addr_d;

  logic                 err;
  logic                 redir;
  logic [FB_32BITS-1:0] target;

  logic                 ifid_load;
  logic                 ifid_bubble;
  logic [FB_32BITS-1:0] ifid_pc_in;
  logic [FB_32BITS-1:0] ifid_inst_in;

  // A prediction error flushes even while ID is stalled; a static
  // prediction only counts when ID is actually advancing.
  assign err    = address_src | register_rst;
  assign redir  = err | (pred_take & ~stall);
  assign target = err ? predict_err_pc : predict_pc;

  // Next-state / datapath control. The request outputs are decoded from
  // registered state only, so nothing here feeds imem_* combinationally.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_pc_d     = buf_pc_q;
    buf_inst_d   = buf_inst_q;
    dis_addr_d   = dis_addr_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_pc_in   = pc_q;
    ifid_inst_in = imem_rdata;

    unique case (state_q)
      FB_IF_IDLE: begin
        state_d = FB_IF_FETCH;
      end

      FB_IF_FETCH: begin
        if (imem_ready) begin
          if (redir) begin
            pc_d        = target;
            ifid_bubble = 1'b1;
          end else if (!stall) begin
            ifid_load = 1'b1;
            pc_d      = fb_next_pc(pc_q);
          end else begin
            // Accepted while ID is frozen: park the word in the skid buffer.
            buf_pc_d   = pc_q;
            buf_inst_d = imem_rdata;
            pc_d       = fb_next_pc(pc_q);
            state_d    = FB_IF_HOLD;
          end
        end else if (redir) begin
          // The request is already on the bus and must stay put until
          // accepted, so remember its address and go drain it.
          dis_addr_d  = pc_q;
          pc_d        = target;
          ifid_bubble = 1'b1;
          state_d     = FB_IF_DISCARD;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end

      FB_IF_HOLD: begin
        if (redir) begin
          pc_d        = target;
          ifid_bubble = 1'b1;
          state_d     = FB_IF_FETCH;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_pc_in   = buf_pc_q;
          ifid_inst_in = buf_inst_q;
          state_d      = FB_IF_FETCH;
        end
      end

      FB_IF_DISCARD: begin
        // Later redirects simply replace the pending target.
        if (redir) begin
          pc_d        = target;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ready) begin
          state_d = FB_IF_FETCH;
        end
      end

      default: begin
        state_d = FB_IF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FB_IF_IDLE;
      pc_q       <= RESET_PC;
      buf_pc_q   <= '0;
      buf_inst_q <= '0;
      dis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      dis_addr_q <= dis_addr_d;
    end
  end

  assign imem_req  = (state_q == FB_IF_FETCH) || (state_q == FB_IF_DISCARD);
  assign imem_addr = (state_q == FB_IF_DISCARD) ? dis_addr_q : pc_q;

  fb_if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .pc_i    (ifid_pc_in),
    .inst_i  (ifid_inst_in),
    .pc_o    (if_id_pc),
    .inst_o  (if_id_inst),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_fb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_fb_if_stage
//   Directed bench for fb_if_stage with a transaction-level reference model
//   and a short randomised tail checked against the same model.
// ---------------------------------------------------------------------------
module tb_fb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        address_src = 1'b0;
  logic        register_rst = 1'b0;
  logic [31:0] predict_err_pc = '0;
  logic        pred_take = 1'b0;
  logic [31:0] predict_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  fb_if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .address_src    (address_src),
    .register_rst   (register_rst),
    .predict_err_pc (predict_err_pc),
    .pred_take      (pred_take),
    .predict_pc     (predict_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable tag plus the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {8'hC3, a[23:0]};
  endfunction

  // Transaction view of the stage: is it still starting up, holding a
  // parked word, or draining a stale request; which PC comes next; and
  // what sits in IF/ID.
  typedef struct packed {
    logic        start;
    logic        hold;
    logic        drop;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.start     = 1'b1;
    r.hold      = 1'b0;
    r.drop      = 1'b0;
    r.pc        = 32'h0;
    r.drop_addr = 32'h0;
    r.buf_pc    = 32'h0;
    r.buf_inst  = 32'h0;
    r.if_pc     = 32'h0;
    r.if_inst   = NOP;
    r.if_valid  = 1'b0;
    return r;
  endfunction

  function automatic model_t model_bubble(input model_t x);
    model_t r = x;
    r.if_valid = 1'b0;
    r.if_inst  = NOP;
    r.if_pc    = 32'h0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic st, as, rr, pt, rdy,
                                        input logic [31:0] perr, ppc, rdata);
    model_t n = c;
    logic e = as | rr;
    logic redirect = e | (pt & ~st);
    logic [31:0] tgt = e ? perr : ppc;
    if (c.start) begin
      n.start = 1'b0;
    end else if (c.hold) begin
      if (redirect) begin
        n = model_bubble(n);
        n.hold = 1'b0;
        n.pc = tgt;
      end else if (!st) begin
        n.hold = 1'b0;
        n.if_pc = c.buf_pc;
        n.if_inst = c.buf_inst;
        n.if_valid = 1'b1;
      end
    end else if (c.drop) begin
      if (redirect) begin
        n = model_bubble(n);
        n.pc = tgt;
      end else if (!st) begin
        n = model_bubble(n);
      end
      if (rdy) n.drop = 1'b0;
    end else if (rdy) begin
      if (redirect) begin
        n = model_bubble(n);
        n.pc = tgt;
      end else if (!st) begin
        n.if_pc = c.pc;
        n.if_inst = rdata;
        n.if_valid = 1'b1;
        n.pc = c.pc + 32'd1;
      end else begin
        n.hold = 1'b1;
        n.buf_pc = c.pc;
        n.buf_inst = rdata;
        n.pc = c.pc + 32'd1;
      end
    end else if (redirect) begin
      n = model_bubble(n);
      n.drop = 1'b1;
      n.drop_addr = c.pc;
      n.pc = tgt;
    end else if (!st) begin
      n = model_bubble(n);
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else m <= model_next(m, stall, address_src, register_rst, pred_take, imem_ready,
                         predict_err_pc, predict_pc, imem_rdata);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every cycle, the DUT must match the model.
  always @(negedge clk) begin
    checkOutput("model imem_req", {31'b0, imem_req}, {31'b0, !m.start && !m.hold});
    checkOutput("model imem_addr", imem_addr, m.drop ? m.drop_addr : m.pc);
    checkOutput("model if_id_valid", {31'b0, if_id_valid}, {31'b0, m.if_valid});
    checkOutput("model if_id_inst", if_id_inst, m.if_inst);
    checkOutput("model if_id_pc", if_id_pc, m.if_pc);
  end

  // Advance one clock and present the inputs for the following cycle.
  task automatic applyStimulus(input logic st, as, rr, pt, rdy,
                               input logic [31:0] perr, ppc);
    @(posedge clk);
    #1;
    stall          = st;
    address_src    = as;
    register_rst   = rr;
    pred_take      = pt;
    imem_ready     = rdy;
    predict_err_pc = perr;
    predict_pc     = ppc;
    imem_rdata     = inst_of(imem_addr);
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("reset imem_addr", imem_addr, 32'h0);
    checkOutput("reset if_id_valid", {31'b0, if_id_valid}, 32'd0);
    checkOutput("reset if_id_inst", if_id_inst, NOP);
    checkOutput("reset if_id_pc", if_id_pc, 32'h0);

    // Release reset: one idle cycle, then streaming with zero-wait memory
    rst = 1'b0;
    imem_ready = 1'b1;
    checkOutput("idle no req", {31'b0, imem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("first req", {31'b0, imem_req}, 32'd1);
    checkOutput("first addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("stream addr1", imem_addr, 32'h1);
    checkOutput("first ifid pc", if_id_pc, 32'h0);
    checkOutput("first ifid inst", if_id_inst, 32'hC300_0000);
    checkOutput("first ifid valid", {31'b0, if_id_valid}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("stream addr4", imem_addr, 32'h4);

    // Stall across the accept at pc=5
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("addr5", imem_addr, 32'h5);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("hold no req", {31'b0, imem_req}, 32'd0);
    checkOutput("hold frozen pc", if_id_pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("hold frozen valid", {31'b0, if_id_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("release ifid pc", if_id_pc, 32'h5);
    checkOutput("release ifid inst", if_id_inst, 32'hC300_0005);
    checkOutput("resume addr6", imem_addr, 32'h6);

    // Static prediction while fetching pc=9
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 32'h40);
    checkOutput("pred addr9", imem_addr, 32'h9);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("pred bubble valid", {31'b0, if_id_valid}, 32'd0);
    checkOutput("pred bubble inst", if_id_inst, NOP);
    checkOutput("pred target addr", imem_addr, 32'h40);

    // Prediction error under stall with a request to 0x11 pending
    applyStimulus(0, 0, 0, 1, 1, 0, 32'h10);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("redir addr 0x10", imem_addr, 32'h10);
    applyStimulus(1, 1, 0, 0, 0, 32'h20, 0);
    checkOutput("ifid 0x10 valid", {31'b0, if_id_valid}, 32'd1);
    checkOutput("pending addr 0x11", imem_addr, 32'h11);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("err bubble despite stall", {31'b0, if_id_valid}, 32'd0);
    checkOutput("discard holds addr", imem_addr, 32'h11);
    checkOutput("discard keeps req", {31'b0, imem_req}, 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("discard still 0x11", imem_addr, 32'h11);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("after discard addr", imem_addr, 32'h20);
    checkOutput("after discard valid", {31'b0, if_id_valid}, 32'd0);

    // Two redirects while discarding: only the last target is fetched
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h30);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h50);
    checkOutput("dbl discard addr", imem_addr, 32'h21);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dbl discard stable", imem_addr, 32'h21);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dbl redirect target", imem_addr, 32'h50);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("wrap top addr", imem_addr, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("wrap next addr", imem_addr, 32'h0);
    checkOutput("wrap ifid pc", if_id_pc, 32'hFFFF_FFFF);

    // Asynchronous reset while in HOLD
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("pre-reset hold req", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("async rst req", {31'b0, imem_req}, 32'd0);
    checkOutput("async rst addr", imem_addr, 32'h0);
    checkOutput("async rst valid", {31'b0, if_id_valid}, 32'd0);
    checkOutput("async rst inst", if_id_inst, NOP);
    checkOutput("async rst pc", if_id_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;

    // Mixed traffic, checked against the model every cycle
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 20) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0, $urandom, $urandom);
    end
    @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
